mem_port_arbiter: RTL and testbench

Shares the single unified memory port of the multicycle core between the instruction-fetch requester (IR load path) and the data requester (MDR load / store path). It runs one transaction at a time: it arbitrates round-robin, drives the memory, counts the fixed memory latency, then returns read data with a one-cycle valid pulse. It sits between the control FSM/datapath and the memory model, so fetch and ld/sd never collide on the port.

---
 rtl/mem_port_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the single memory port between the instruction-fetch requester and
// the data (load/store) requester. Only one transaction is in flight at a
// time. Ties are broken round-robin. The memory latency is a fixed count, and
// each transaction ends with a one-cycle rvalid pulse to the requester that
// owns it.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             owner_d;   // 1 = data requester owns the transaction in flight
  logic             owner_we;  // transaction in flight is a store
  logic             last_d;    // 1 = data side won the most recent grant
  logic             grant_i, grant_d;
  logic             capture;

  // Arbitration happens only in IDLE. A lone requester wins. On a tie, the
  // side that was not granted last wins. The reset term keeps grants low
  // while reset is held.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state == IDLE && reset) begin
      if (i_req && d_req) begin
        grant_i = last_d;
        grant_d = ~last_d;
      end else begin
        grant_i = i_req;
        grant_d = d_req;
      end
    end
  end

  // Route the winner onto the memory port. The port reads as all zeros when idle.
  always_comb begin
    mem_en    = grant_i | grant_d;
    mem_we    = grant_d & d_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (grant_d) begin
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (grant_i) begin
      mem_addr  = i_addr;
    end
  end

  // Next-state logic: grant -> count the memory latency -> respond -> idle.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    unique case (state)
      IDLE: begin
        if (grant_i || grant_d) begin
          state_next = WAIT;
          cnt_next   = CNT_W'(MEM_LAT);
        end
      end
      WAIT: begin
        cnt_next = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_next = RESP;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Read data is valid on the last WAIT cycle. Stores return no data.
  assign capture = (state == WAIT) && (cnt == CNT_W'(1)) && !(owner_d && owner_we);

  // State and latency counter registers.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments, so every flop
    // samples the values present before the clock edge.
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Record the owner of the transaction and the round-robin history on each grant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_d  <= 1'b0;
      owner_we <= 1'b0;
      last_d   <= 1'b1;
    end else if (grant_i || grant_d) begin
      owner_d  <= grant_d;
      owner_we <= grant_d & d_we;
      last_d   <= grant_d;
    end
  end

  // Capture read data into the owner's register. It holds until the next capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      i_rdata <= '0;
      d_rdata <= '0;
    end else if (capture) begin
      if (owner_d) d_rdata <= mem_rdata;
      else         i_rdata <= mem_rdata;
    end
  end

  assign i_gnt    = grant_i;
  assign d_gnt    = grant_d;
  assign i_rvalid = (state == RESP) && !owner_d;
  assign d_rvalid = (state == RESP) && owner_d;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Drivers push the expected response into per-requester queues when they
// issue a request. A negedge monitor predicts grant, port, busy and rvalid
// timing from the transaction rules and compares them on every cycle. It pops
// the expected data whenever an rvalid appears.
module tb_mem_port_arbiter;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 64;
  localparam int MEM_LAT = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              i_req = 1'b1;
  logic [ADDR_W-1:0] i_addr = 32'h0000_0040;
  logic              i_gnt, i_rvalid;
  logic [DATA_W-1:0] i_rdata;
  logic              d_req = 1'b1;
  logic              d_we = 1'b1;
  logic [ADDR_W-1:0] d_addr = 32'h0000_0100;
  logic [DATA_W-1:0] d_wdata = 64'h1234;
  logic              d_gnt, d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              busy;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [230:0] all_out;
  assign all_out = {i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
                    mem_en, mem_we, mem_addr, mem_wdata, busy};

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Memory contents: the memory model and the reference shadow start from the same seed.
  function automatic logic [63:0] seed_val(input logic [31:0] a);
    return {a ^ 32'h5a5a_a5a5, ~a};
  endfunction

  logic [63:0] mem_arr [logic [31:0]];
  logic [63:0] shadow  [logic [31:0]];

  function automatic logic [63:0] mem_read(input logic [31:0] a);
    return mem_arr.exists(a) ? mem_arr[a] : seed_val(a);
  endfunction

  function automatic logic [63:0] model_read(input logic [31:0] a);
    return shadow.exists(a) ? shadow[a] : seed_val(a);
  endfunction

  // Memory model. Read data is presented only around the sampling edge MEM_LAT
  // cycles after mem_en. At all other times the bus carries garbage.
  bit          resp_pend = 1'b0;
  int          resp_cyc  = 0;
  logic [31:0] resp_addr = '0;

  always @(negedge clk) begin
    if (resp_pend && cyc == resp_cyc) begin
      mem_rdata = mem_read(resp_addr);
      resp_pend = 1'b0;
    end else begin
      mem_rdata = {$urandom, $urandom};
    end
    if (reset && mem_en) begin
      if (mem_we) mem_arr[mem_addr] = mem_wdata;
      else begin
        resp_pend = 1'b1;
        resp_cyc  = cyc + MEM_LAT;
        resp_addr = mem_addr;
      end
    end
  end

  // Scoreboard queues and the transaction-level port model.
  logic [63:0] i_q[$];
  logic [63:0] d_q[$];
  logic [63:0] exp_d_hold = '0;
  int          gl_cyc[$];
  bit          gl_d[$];

  bit m_last_was_d = 1'b1;
  int m_gnt_cyc    = -100;
  bit m_pend       = 1'b0;
  int m_done       = 0;
  bit m_own_d      = 1'b0;

  always @(negedge clk) begin : monitor
    logic        ei, ed, free, ev_i, ev_d;
    logic [97:0] exp_bus;
    if (!reset) begin
      m_pend       = 1'b0;
      m_last_was_d = 1'b1;
      m_gnt_cyc    = -100;
      check("reset_outputs_zero", all_out, '0);
    end else begin
      // The port is free once the previous transaction has used its MEM_LAT+2 cycles.
      free = (cyc - m_gnt_cyc) > MEM_LAT + 1;
      ei = 1'b0;
      ed = 1'b0;
      if (free) begin
        if (i_req && d_req) begin
          ei = m_last_was_d;
          ed = !m_last_was_d;
        end else begin
          ei = i_req;
          ed = d_req;
        end
      end
      check("grant", {i_gnt, d_gnt}, {ei, ed});
      check("busy", busy, !free);
      exp_bus = '0;
      if (ed)      exp_bus = {1'b1, d_we, d_addr, d_wdata};
      else if (ei) exp_bus = {1'b1, 1'b0, i_addr, 64'h0};
      check("mem_bus", {mem_en, mem_we, mem_addr, mem_wdata}, exp_bus);
      ev_i = m_pend && (cyc == m_done) && !m_own_d;
      ev_d = m_pend && (cyc == m_done) && m_own_d;
      check("rvalid", {i_rvalid, d_rvalid}, {ev_i, ev_d});
      if (i_rvalid) begin
        if (i_q.size() == 0) check("i_rvalid_unexpected", 1, 0);
        else                 check("i_rdata", i_rdata, i_q.pop_front());
      end
      if (d_rvalid) begin
        if (d_q.size() == 0) check("d_rvalid_unexpected", 1, 0);
        else                 check("d_rdata", d_rdata, d_q.pop_front());
      end
      if (m_pend && cyc == m_done) m_pend = 1'b0;
      if (ei || ed) begin
        m_pend       = 1'b1;
        m_done       = cyc + MEM_LAT + 1;
        m_own_d      = ed;
        m_gnt_cyc    = cyc;
        m_last_was_d = ed;
        gl_cyc.push_back(cyc);
        gl_d.push_back(ed);
      end
    end
  end

  // Drivers. Each call starts 1 time unit after a rising edge and returns
  // aligned the same way.
  task automatic do_fetch(input logic [31:0] a);
    bit ok;
    i_q.push_back(model_read(a));
    i_addr = a;
    i_req  = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin @(negedge clk); ok = i_gnt; end
    if (!ok) check("i_gnt_timeout", 0, 1);
    @(posedge clk); #1;
    i_req  = 1'b0;
    i_addr = $urandom;
    ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin @(negedge clk); ok = i_rvalid; end
    if (!ok) check("i_rvalid_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic do_data(input logic we, input logic [31:0] a, input logic [63:0] wd);
    bit ok;
    if (we) shadow[a] = wd;
    else    exp_d_hold = model_read(a);
    d_q.push_back(exp_d_hold);
    d_we    = we;
    d_addr  = a;
    d_wdata = wd;
    d_req   = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin @(negedge clk); ok = d_gnt; end
    if (!ok) check("d_gnt_timeout", 0, 1);
    @(posedge clk); #1;
    d_req   = 1'b0;
    d_we    = $urandom_range(0, 1);
    d_addr  = $urandom;
    d_wdata = {$urandom, $urandom};
    ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin @(negedge clk); ok = d_rvalid; end
    if (!ok) check("d_rvalid_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic idle_gap();
    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int rel, c0;
    mem_arr[32'h40] = 64'h0000_0000_00A0_0093;
    shadow[32'h40]  = 64'h0000_0000_00A0_0093;

    // Hold reset with both requests high: every output must stay 0.
    @(negedge clk);
    check("reset_hold_outputs", all_out, '0);
    repeat (2) @(posedge clk);
    #1;

    // Tie and fairness straight out of reset: I, D, I, D every MEM_LAT+2 cycles.
    reset = 1'b1;
    rel   = cyc;
    gl_cyc.delete(); gl_d.delete();
    fork
      begin do_fetch(32'h1000); do_fetch(32'h1008); end
      begin do_data(1'b0, 32'h8000, '0); do_data(1'b0, 32'h8008, '0); end
    join
    check("tie_grant_count", gl_cyc.size(), 4);
    if (gl_cyc.size() == 4) begin
      check("first_grant_after_release", gl_cyc[0], rel);
      for (int k = 0; k < 4; k++) begin
        check("tie_grant_cycle", gl_cyc[k] - gl_cyc[0], 4 * k);
        check("tie_grant_owner", gl_d[k], k % 2);
      end
    end

    // Single fetch from 0x40.
    gl_cyc.delete(); gl_d.delete();
    c0 = cyc;
    do_fetch(32'h40);
    if (gl_cyc.size() > 0) check("fetch_grant_cycle", gl_cyc[0], c0);
    else                   check("fetch_grant_seen", 0, 1);
    repeat (2) @(posedge clk);
    #1;
    check("fetch_rdata_held", i_rdata, 64'h0000_0000_00A0_0093);

    // Store, then load the same doubleword back.
    do_data(1'b1, 32'h100, 64'h0000_0000_DEAD_BEEF);
    do_data(1'b0, 32'h100, 64'h0);
    check("store_load_back", d_rdata, 64'h0000_0000_DEAD_BEEF);

    // A data request raised while the port is busy waits for the next IDLE.
    gl_cyc.delete(); gl_d.delete();
    fork
      do_fetch(32'h1010);
      begin @(posedge clk); #1; do_data(1'b0, 32'h8010, '0); end
    join
    check("busy_grant_count", gl_cyc.size(), 2);
    if (gl_cyc.size() == 2) begin
      check("busy_d_grant_delay", gl_cyc[1] - gl_cyc[0], 4);
      check("busy_d_grant_owner", gl_d[1], 1);
    end

    // Reset in the middle of a fetch: no rvalid for it, fresh grant right after release.
    gl_cyc.delete(); gl_d.delete();
    i_addr = 32'h2000;
    i_req  = 1'b1;
    c0 = cyc;
    @(negedge clk);
    check("midreset_grant", i_gnt, 1);
    @(posedge clk); #1;
    i_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("async_reset_clear", all_out, '0);
    exp_d_hold = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    rel = cyc;
    do_fetch(32'h2008);
    check("midreset_grant_count", gl_cyc.size(), 2);
    if (gl_cyc.size() == 2) check("regrant_after_release", gl_cyc[1], rel);

    // Randomized traffic from both requesters.
    fork
      for (int n = 0; n < 40; n++) begin
        idle_gap();
        do_fetch(32'h1000 + ($urandom_range(0, 63) << 3));
      end
      for (int n = 0; n < 40; n++) begin
        idle_gap();
        do_data(1'($urandom_range(0, 1)), 32'h8000 + ($urandom_range(0, 15) << 3),
                {$urandom, $urandom});
      end
    join

    repeat (6) @(posedge clk);
    #1;
    check("i_queue_drained", i_q.size(), 0);
    check("d_queue_drained", d_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
